// File: rtl/writeback_queue_pkg.sv
// Shared constants and entry type for the register-file writeback queue.
// Default geometry: 4 entries of {2-bit index, 16-bit data}.
package writeback_queue_pkg;

   localparam int WBQ_DEPTH  = 4;
   localparam int WBQ_DATA_W = 16;
   localparam int WBQ_ADDR_W = 2;

   typedef struct packed {
      logic [WBQ_ADDR_W-1:0] addr;
      logic [WBQ_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_queue_fwd_match.sv
// wbq_fwd_match: scans occupied queue slots from head (oldest) to tail
// (youngest) and returns the data of the youngest entry whose index matches.
module wbq_fwd_match
   import writeback_queue_pkg::*;
#(
   parameter int DEPTH  = WBQ_DEPTH,
   parameter int DATA_W = WBQ_DATA_W,
   parameter int ADDR_W = WBQ_ADDR_W
) (
   input  logic [DEPTH-1:0][ADDR_W-1:0] i_addr,
   input  logic [DEPTH-1:0][DATA_W-1:0] i_data,
   input  logic [$clog2(DEPTH)-1:0]     i_head,
   input  logic [$clog2(DEPTH):0]       i_count,
   input  logic [ADDR_W-1:0]            i_lookup,
   output logic                         o_hit,
   output logic [DATA_W-1:0]            o_data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Later (younger) matches overwrite earlier ones, so the last hit wins.
   always_comb begin
      logic [PTR_W-1:0] w_idx;
      w_idx  = '0;
      o_hit  = 1'b0;
      o_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_head + PTR_W'(k);
         if ((CNT_W'(k) < i_count) && (i_addr[w_idx] == i_lookup)) begin
            o_hit  = 1'b1;
            o_data = i_data[w_idx];
         end
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: two-producer (mem, alu) FIFO feeding one register-file write
// port, with optional pending-value forwarding built when WBQ_FORWARD_EN is defined.
module writeback_queue
   import writeback_queue_pkg::*;
#(
   parameter int DEPTH  = WBQ_DEPTH,
   parameter int DATA_W = WBQ_DATA_W,
   parameter int ADDR_W = WBQ_ADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [ADDR_W-1:0]        mem_addr,
   input  logic [DATA_W-1:0]        mem_data,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDR_W-1:0]        alu_addr,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     drain_en,
   output logic                     reg_write_signal,
   output logic [ADDR_W-1:0]        write_addr,
   output logic [DATA_W-1:0]        write_data,
   input  logic [ADDR_W-1:0]        rd_addr1,
   input  logic [ADDR_W-1:0]        rd_addr2,
   output logic                     fwd1_hit,
   output logic                     fwd2_hit,
   output logic [DATA_W-1:0]        fwd1_data,
   output logic [DATA_W-1:0]        fwd2_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
   logic [DEPTH-1:0][DATA_W-1:0] r_data;
   logic [PTR_W-1:0]             r_wr_ptr;
   logic [PTR_W-1:0]             r_rd_ptr;
   logic [CNT_W-1:0]             r_count;

   logic w_mem_ready, w_alu_ready, w_mem_fire, w_alu_fire, w_deq;
   logic [PTR_W-1:0] w_alu_slot;

   // Readiness looks only at the registered count; a same-cycle drain earns no credit.
   assign w_mem_ready = !reset && (r_count < FULL_CNT);
   assign w_alu_ready = !reset && ((r_count + CNT_W'(w_mem_fire)) < FULL_CNT);
   assign w_mem_fire  = mem_valid & w_mem_ready;
   assign w_alu_fire  = alu_valid & w_alu_ready;
   assign w_deq       = !reset && (r_count != '0) && drain_en;
   assign w_alu_slot  = r_wr_ptr + PTR_W'(w_mem_fire);

   assign mem_ready        = w_mem_ready;
   assign alu_ready        = w_alu_ready;
   assign reg_write_signal = w_deq;
   assign write_addr       = w_deq ? r_addr[r_rd_ptr] : '0;
   assign write_data       = w_deq ? r_data[r_rd_ptr] : '0;
   assign count            = r_count;
   assign empty            = (r_count == '0);
   assign full             = (r_count == FULL_CNT);

   // NOTE: storage has no reset; occupancy (pointers/count) alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (w_mem_fire) begin
         r_addr[r_wr_ptr] <= mem_addr;
         r_data[r_wr_ptr] <= mem_data;
      end
      if (w_alu_fire) begin
         r_addr[w_alu_slot] <= alu_addr;
         r_data[w_alu_slot] <= alu_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_mem_fire) + PTR_W'(w_alu_fire);
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_deq);
         r_count  <= r_count + CNT_W'(w_mem_fire) + CNT_W'(w_alu_fire) - CNT_W'(w_deq);
      end
   end

`ifdef WBQ_FORWARD_EN
   logic              w_hit1, w_hit2;
   logic [DATA_W-1:0] w_data1, w_data2;

   wbq_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
      .i_addr   (r_addr),
      .i_data   (r_data),
      .i_head   (r_rd_ptr),
      .i_count  (r_count),
      .i_lookup (rd_addr1),
      .o_hit    (w_hit1),
      .o_data   (w_data1)
   );

   wbq_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
      .i_addr   (r_addr),
      .i_data   (r_data),
      .i_head   (r_rd_ptr),
      .i_count  (r_count),
      .i_lookup (rd_addr2),
      .o_hit    (w_hit2),
      .o_data   (w_data2)
   );

   assign fwd1_hit  = !reset && w_hit1;
   assign fwd2_hit  = !reset && w_hit2;
   assign fwd1_data = reset ? '0 : w_data1;
   assign fwd2_data = reset ? '0 : w_data2;
`else
   logic w_unused_rd;
   assign w_unused_rd = ^{rd_addr1, rd_addr2};
   assign fwd1_hit    = 1'b0;
   assign fwd2_hit    = 1'b0;
   assign fwd1_data   = '0;
   assign fwd2_data   = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue; expectations follow WBQ_FORWARD_EN
// (forwarding results expected only when the macro is defined).
module tb_writeback_queue;
   import writeback_queue_pkg::*;

`ifdef WBQ_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_valid, alu_valid, drain_en;
   logic        mem_ready, alu_ready;
   logic [1:0]  mem_addr, alu_addr, rd_addr1, rd_addr2;
   logic [15:0] mem_data, alu_data;
   logic        reg_write_signal, fwd1_hit, fwd2_hit, empty, full;
   logic [1:0]  write_addr;
   logic [15:0] write_data, fwd1_data, fwd2_data;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   wb_entry_t vec [5];

   writeback_queue dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
      .drain_en(drain_en),
      .reg_write_signal(reg_write_signal), .write_addr(write_addr), .write_data(write_data),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
      .count(count), .empty(empty), .full(full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge, then let outputs settle before checks.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; drain_en = 1'b0;
      mem_valid = 1'b1; mem_addr = 2'd3; mem_data = 16'hBEEF;
      alu_valid = 1'b1; alu_addr = 2'd3; alu_data = 16'hDEAD;
      rd_addr1 = 2'd3; rd_addr2 = 2'd0;
      tick(); tick();
      check("rst_mem_ready", mem_ready, 0);
      check("rst_alu_ready", alu_ready, 0);
      check("rst_reg_write", reg_write_signal, 0);
      check("rst_fwd1_hit", fwd1_hit, 0);
      check("rst_fwd2_hit", fwd2_hit, 0);

      // Release reset; offers made during reset must have been dropped.
      reset = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0; #1;
      check("post_rst_count", count, 0);
      check("post_rst_empty", empty, 1);
      check("post_rst_full", full, 0);

      // Single mem write, drained the following cycle.
      mem_valid = 1'b1; mem_addr = 2'd1; mem_data = 16'h00AA; drain_en = 1'b1; #1;
      check("single_mem_ready", mem_ready, 1);
      check("single_no_early_write", reg_write_signal, 0);
      tick();
      mem_valid = 1'b0; #1;
      check("single_we", reg_write_signal, 1);
      check("single_waddr", write_addr, 1);
      check("single_wdata", write_data, 16'h00AA);
      tick();
      check("single_empty", empty, 1);
      check("single_idle_we", reg_write_signal, 0);
      check("single_idle_waddr", write_addr, 0);
      check("single_idle_wdata", write_data, 0);

      // Simultaneous mem+alu to the same index; alu is younger and forwards.
      drain_en = 1'b0; rd_addr1 = 2'd2; rd_addr2 = 2'd3;
      mem_valid = 1'b1; mem_addr = 2'd2; mem_data = 16'h1111;
      alu_valid = 1'b1; alu_addr = 2'd2; alu_data = 16'h2222; #1;
      check("dual_alu_ready", alu_ready, 1);
      check("dual_arriving_no_fwd", fwd1_hit, 0);
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0; #1;
      check("dual_count", count, 2);
      check("dual_fwd1_hit", fwd1_hit, FWD);
      check("dual_fwd1_data", fwd1_data, FWD ? 16'h2222 : 16'h0);
      check("dual_fwd2_miss", fwd2_hit, 0);
      check("dual_held_we", reg_write_signal, 0);
      drain_en = 1'b1; #1;
      check("dual_w0_we", reg_write_signal, 1);
      check("dual_w0_addr", write_addr, 2);
      check("dual_w0_data", write_data, 16'h1111);
      check("dual_head_fwd", fwd1_data, FWD ? 16'h2222 : 16'h0);
      tick();
      check("dual_w1_data", write_data, 16'h2222);
      check("dual_w1_count", count, 1);
      check("dual_w1_fwd_hit", fwd1_hit, FWD);
      tick();
      check("dual_done_empty", empty, 1);

      // Fill with alu offers while drain is off; the fifth must be held.
      for (int i = 0; i < 5; i++) begin
         vec[i].addr = 2'(i);
         vec[i].data = 16'h0030 + 16'(i);
      end
      drain_en = 1'b0; alu_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alu_addr = vec[i].addr; alu_data = vec[i].data; #1;
         check($sformatf("fill_ready_%0d", i), alu_ready, 1);
         tick();
      end
      alu_addr = vec[4].addr; alu_data = vec[4].data; #1;
      check("fill_full", full, 1);
      check("fill_count", count, 4);
      check("fill_alu_ready", alu_ready, 0);
      check("fill_mem_ready", mem_ready, 0);
      tick();
      check("fill_held_count", count, 4);
      drain_en = 1'b1; #1;
      check("fill_no_credit", alu_ready, 0);
      check("fill_d0", write_data, vec[0].data);
      tick();
      check("fill_ready_after_drain", alu_ready, 1);
      check("fill_d1", write_data, vec[1].data);
      tick();
      alu_valid = 1'b0; #1;
      check("fill_count_after_swap", count, 3);
      for (int i = 2; i < 5; i++) begin
         check($sformatf("fill_d%0d", i), write_data, vec[i].data);
         tick();
      end
      check("fill_drained", empty, 1);

      // Streaming: one in, one out per cycle across several pointer wraps.
      drain_en = 1'b1; mem_valid = 1'b1; mem_addr = 2'd1;
      for (int i = 0; i < 10; i++) begin
         mem_data = 16'(i); #1;
         if (i > 0) begin
            check($sformatf("stream_data_%0d", i - 1), write_data, 16'(i - 1));
            check($sformatf("stream_count_%0d", i - 1), count, 1);
         end
         tick();
      end
      mem_valid = 1'b0; #1;
      check("stream_data_9", write_data, 16'd9);
      check("stream_count_9", count, 1);
      tick();
      check("stream_empty", empty, 1);

      // Reset discards queued entries and a concurrent offer.
      drain_en = 1'b0; mem_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mem_addr = 2'(i); mem_data = 16'h0500 + 16'(i);
         tick();
      end
      check("pre_rst_count", count, 3);
      reset = 1'b1; #1;
      check("mid_rst_mem_ready", mem_ready, 0);
      tick();
      reset = 1'b0; mem_valid = 1'b0; drain_en = 1'b1; #1;
      check("flush_count", count, 0);
      check("flush_we", reg_write_signal, 0);
      tick();
      check("flush_we_later", reg_write_signal, 0);
      check("flush_empty", empty, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, 4, number of queue entries; SHALL be a power of two and at least 2.
REQ-002 Parameter DATA_W, 16, register data width.
REQ-003 Parameter ADDR_W, 2, register index width.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mem_valid/mem_ready  in/out  1/1  load-result producer handshake; mem_addr  in  ADDR_W; mem_data  in  DATA_W.
REQ-007 alu_valid/alu_ready  in/out  1/1  ALU-result producer handshake; alu_addr  in  ADDR_W; alu_data  in  DATA_W.
REQ-008 drain_en  in  1  permits a register-file write this cycle.
REQ-009 reg_write_signal  out  1; write_addr  out  ADDR_W; write_data  out  DATA_W; these drive the register-file write port.
REQ-010 rd_addr1, rd_addr2  in  ADDR_W  lookup indices, matching the register-file read addresses.
REQ-011 fwd1_hit, fwd2_hit  out  1; fwd1_data, fwd2_data  out  DATA_W  pending-value forwarding.
REQ-012 count  out  log2(DEPTH)+1  occupied entries; empty  out  1; full  out  1.

Function
REQ-013 Transfer on a port SHALL occur when valid and ready are both high at a rising edge.
REQ-014 mem_ready SHALL equal (count < DEPTH), and alu_ready SHALL equal (count + (mem_valid & mem_ready) < DEPTH); readiness SHALL use the registered count only, with no credit for a same-cycle dequeue.
REQ-015 Simultaneous transfers SHALL enqueue mem first, then alu, so the ALU entry is younger.
REQ-016 The queue SHALL be FIFO; head entry SHALL drive write_addr/write_data combinationally.
REQ-017 reg_write_signal SHALL equal (!empty & drain_en); when it is high at an edge, the head SHALL be removed.
REQ-018 When reg_write_signal is low, write_addr and write_data SHALL be 0.
REQ-019 Minimum latency from accepted transfer to reg_write_signal high SHALL be 1 cycle; throughput SHALL be one write per cycle.
REQ-020 Enqueue and dequeue in the same cycle SHALL be allowed; count SHALL change by (#enq - #deq).
REQ-021 Read/write pointers SHALL wrap modulo DEPTH.
REQ-022 full SHALL be (count == DEPTH); empty SHALL be (count == 0).
REQ-023 fwdN_hit SHALL be high when any stored entry's address equals rd_addrN, including the head being written this cycle; fwdN_data SHALL be the youngest matching entry's data, else 0.
REQ-024 Entries arriving this cycle SHALL NOT forward.
REQ-025 Duplicate addresses in the queue SHALL all be written in order.

Reset
REQ-026 With reset high at an edge, pointers and count SHALL clear to 0 and all queued entries SHALL be discarded, including entries mid-flight.
REQ-027 While reset is high, mem_ready, alu_ready, reg_write_signal, fwd1_hit and fwd2_hit SHALL be 0.
REQ-028 After reset, count SHALL be 0, empty SHALL be 1, and full SHALL be 0; a transfer offered during reset SHALL be dropped.

Configuration
REQ-029 Macro WBQ_FORWARD_EN defined: forwarding logic per REQ-023/024 SHALL be built.
REQ-030 Macro WBQ_FORWARD_EN undefined: fwd1_hit, fwd2_hit, fwd1_data and fwd2_data SHALL be tied to 0, with no comparator logic built.

Structure
REQ-031 A shared package SHALL hold the default DATA_W/ADDR_W/DEPTH constants and the wb_entry_t typedef (addr, data).
REQ-032 One sub-module, wbq_fwd_match, SHALL implement the youngest-match search, instantiated twice.

Verification
REQ-033 Reset, then mem (addr 1, data 16'h00AA) once with drain_en=1 -> next cycle reg_write_signal=1, write_addr=1, write_data=16'h00AA; then empty=1.
REQ-034 Same cycle mem (2, 16'h1111) and alu (2, 16'h2222) with drain_en=0; rd_addr1=2 -> fwd1_hit=1 and fwd1_data=16'h2222; then drain_en=1 -> writes 1111 then 2222 on consecutive cycles.
REQ-035 drain_en=0 with 5 alu offers -> 4 accepted; full=1, alu_ready=0 and mem_ready=0; the 5th is held until a drain.
REQ-036 Sustained mem enqueue and drain for 10 cycles, data 0..9 -> count steady at 1, writes in order 0..9, pointer wrap verified.
REQ-037 3 entries queued, reset asserted for 1 cycle -> count=0 and no reg_write_signal afterwards.
REQ-038 Without WBQ_FORWARD_EN, rerun REQ-034 -> fwd1_hit=0 and fwd1_data=0.
